// File: rtl/seg7_capture.sv
// Seven-segment capture: synchronizes an active-low segment bus, waits for a stable pattern
// and reports its digit once. Optional macro HEX_DECODE_EN adds the A-F glyphs.
module seg7_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic [6:0] iSeg,
    output logic [3:0] oData,
    output logic       oValid,
    output logic       oErr,
    output logic       oBlank
);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HOLD
    } state_t;

    localparam logic [6:0]       SEG_OFF  = 7'h7F;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           r_state;
    logic [6:0]       r_s1;
    logic [6:0]       r_s2;
    logic [6:0]       r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_data;
    logic             r_valid;
    logic             r_err;
    logic             r_blank;

    state_t           w_stateNext;
    logic [6:0]       w_prevNext;
    logic [CNT_W-1:0] w_cntNext;
    logic [3:0]       w_dataNext;
    logic             w_validNext;
    logic             w_errNext;
    logic             w_blankNext;
    logic             w_legal;
    logic [3:0]       w_code;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_s1 <= SEG_OFF;
            r_s2 <= SEG_OFF;
        end else begin
            r_s1 <= iSeg;
            r_s2 <= r_s1;
        end
    end

    always_comb begin
        w_legal = 1'b1;
        w_code  = 4'h0;
        case (r_prev)
            7'h40: w_code = 4'h0;
            7'h79: w_code = 4'h1;
            7'h24: w_code = 4'h2;
            7'h30: w_code = 4'h3;
            7'h19: w_code = 4'h4;
            7'h12: w_code = 4'h5;
            7'h02: w_code = 4'h6;
            7'h78: w_code = 4'h7;
            7'h00: w_code = 4'h8;
            7'h10: w_code = 4'h9;
`ifdef HEX_DECODE_EN
            7'h08: w_code = 4'hA;
            7'h03: w_code = 4'hB;
            7'h46: w_code = 4'hC;
            7'h21: w_code = 4'hD;
            7'h06: w_code = 4'hE;
            7'h0E: w_code = 4'hF;
`endif
            default: w_legal = 1'b0;
        endcase
    end

    // A pattern change always restarts filtering, so it is checked before any report.
    always_comb begin
        w_stateNext = r_state;
        w_prevNext  = r_prev;
        w_cntNext   = r_cnt;
        w_dataNext  = r_data;
        w_validNext = 1'b0;
        w_errNext   = 1'b0;
        w_blankNext = r_blank;
        if (r_s2 != r_prev) begin
            w_prevNext  = r_s2;
            w_cntNext   = '0;
            w_stateNext = TRACK;
            w_blankNext = 1'b0;
        end else if (r_state == TRACK) begin
            if (r_cnt < CNT_LAST) begin
                w_cntNext = r_cnt + 1'b1;
            end else begin
                w_stateNext = HOLD;
                if (r_prev == SEG_OFF) begin
                    w_blankNext = 1'b1;
                end else if (w_legal) begin
                    w_dataNext  = w_code;
                    w_validNext = 1'b1;
                end else begin
                    w_errNext = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= IDLE;
            r_prev  <= SEG_OFF;
            r_cnt   <= '0;
            r_data  <= 4'h0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_blank <= 1'b1;
        end else begin
            r_state <= w_stateNext;
            r_prev  <= w_prevNext;
            r_cnt   <= w_cntNext;
            r_data  <= w_dataNext;
            r_valid <= w_validNext;
            r_err   <= w_errNext;
            r_blank <= w_blankNext;
        end
    end

    assign oData  = r_data;
    assign oValid = r_valid;
    assign oErr   = r_err;
    assign oBlank = r_blank;

endmodule

// File: tb/tb_seg7_capture.sv
// Randomized scoreboard bench for seg7_capture; expectations come from a run-length model
// of the sampled input bus, honouring HEX_DECODE_EN when it is defined.
module tb_seg7_capture;

    localparam int STABLE = 4;
    localparam int KIND_CLEAR = 0;
    localparam int KIND_VALID = 1;
    localparam int KIND_ERR   = 2;
    localparam int KIND_BLANK = 3;

    typedef struct {
        int         atEdge;
        int         kind;
        logic [3:0] data;
    } ev_t;

    logic       iClk = 1'b0;
    logic       iRst_n = 1'b0;
    logic [6:0] iSeg = 7'h40;
    logic [3:0] oData;
    logic       oValid;
    logic       oErr;
    logic       oBlank;

    ev_t        evQ[$];
    int         edgeNow = 0;
    logic [6:0] lastSample = 7'h7F;
    int         runLen = 1000;
    int         vectors = 0;
    int         miscompares = 0;

    logic [3:0] expData = 4'h0;
    logic       expValid = 1'b0;
    logic       expErr = 1'b0;
    logic       expBlank = 1'b1;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_capture #(.STABLE_CYCLES(STABLE), .CNT_W(3)) dut (
        .iClk  (iClk),
        .iRst_n(iRst_n),
        .iSeg  (iSeg),
        .oData (oData),
        .oValid(oValid),
        .oErr  (oErr),
        .oBlank(oBlank)
    );

    always #5 iClk = ~iClk;

    function automatic int glyphCount();
`ifdef HEX_DECODE_EN
        return 16;
`else
        return 10;
`endif
    endfunction

    // Builds the expected report for a pattern that has been stable long enough.
    function automatic ev_t makeReport(input logic [6:0] pat, input int atEdge);
        ev_t e;
        e.atEdge = atEdge;
        e.data   = 4'h0;
        e.kind   = KIND_ERR;
        if (pat == 7'h7F) e.kind = KIND_BLANK;
        for (int i = 0; i < glyphCount(); i++) begin
            if (glyph[i] == pat) begin
                e.kind = KIND_VALID;
                e.data = 4'(i);
            end
        end
        return e;
    endfunction

    // Each run of identical input samples reports once, two edges after its (STABLE+1)th sample.
    always @(posedge iClk or negedge iRst_n) begin
        ev_t e;
        if (!iRst_n) begin
            evQ.delete();
            lastSample = 7'h7F;
            runLen = 1000;
        end else begin
            edgeNow++;
            if (iSeg != lastSample) begin
                lastSample = iSeg;
                runLen = 1;
                e.atEdge = edgeNow + 2;
                e.kind = KIND_CLEAR;
                e.data = 4'h0;
                evQ.push_back(e);
            end else if (runLen < 1000) begin
                runLen++;
            end
            if (runLen == STABLE + 1) evQ.push_back(makeReport(lastSample, edgeNow + 2));
        end
    end

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at edge %0d: got %h expected %h", name, edgeNow, act, exp);
        end
    endtask

    always @(negedge iClk) begin
        ev_t e;
        expValid = 1'b0;
        expErr = 1'b0;
        if (!iRst_n) begin
            expData = 4'h0;
            expBlank = 1'b1;
        end else begin
            while (evQ.size() > 0 && evQ[0].atEdge <= edgeNow) begin
                e = evQ.pop_front();
                case (e.kind)
                    KIND_CLEAR: expBlank = 1'b0;
                    KIND_BLANK: expBlank = 1'b1;
                    KIND_VALID: begin
                        expValid = 1'b1;
                        expData = e.data;
                    end
                    default: expErr = 1'b1;
                endcase
            end
        end
        checkOutput("oValid", {3'b0, oValid}, {3'b0, expValid});
        checkOutput("oErr", {3'b0, oErr}, {3'b0, expErr});
        checkOutput("oData", oData, expData);
        checkOutput("oBlank", {3'b0, oBlank}, {3'b0, expBlank});
    end

    task automatic applyStimulus(input logic [6:0] pat, input int cycles);
        @(negedge iClk);
        #1 iSeg = pat;
        repeat (cycles) @(posedge iClk);
    endtask

    task automatic setReset(input logic level);
        @(negedge iClk);
        #2 iRst_n = level;
    endtask

    initial begin
        logic [6:0] pat;
        $display("[TB] seg7_capture scoreboard bench, STABLE_CYCLES=%0d", STABLE);
        repeat (3) @(posedge iClk);
        setReset(1'b1);
        repeat (10) @(posedge iClk);

        for (int d = 0; d < 10; d++) applyStimulus(glyph[d], 10);

        applyStimulus(7'h24, 10);
        applyStimulus(7'h79, 1);
        applyStimulus(7'h24, 10);

        applyStimulus(7'h7E, 10);
        applyStimulus(7'h7F, 10);

        applyStimulus(7'h30, 3);
        setReset(1'b0);
        repeat (2) @(posedge iClk);
        setReset(1'b1);
        repeat (12) @(posedge iClk);

        applyStimulus(7'h08, 10);
        applyStimulus(7'h46, 10);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0: pat = glyph[$urandom_range(0, 9)];
                1: pat = glyph[$urandom_range(10, 15)];
                2: pat = 7'h7F;
                default: pat = 7'($urandom_range(0, 127));
            endcase
            applyStimulus(pat, $urandom_range(1, 8));
        end

        applyStimulus(7'h12, 12);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
